vector_c_reduce: RTL and testbench
==================================

// Module: vector_c_reduce
// PURPOSE
//   Downstream consumer of result vector C (5-bit entries, one per address).
//   On a start pulse, scans every C entry in address order through a shared,
//   arbitrated read port and reports the sum, the maximum and its address,
//   and the count of entries with the carry bit (bit 4) set.
//   Results feed the 7-seg display and debug readout logic.
//   The block never writes memory.
// PARAMETERS
//   ADDR_W  10    address width of vector C memory
//   DEPTH   1024  number of entries scanned (addresses 0..DEPTH-1)
//   DATA_W  5     C entry width; bit DATA_W-1 is the carry bit
//   RD_LAT  1     cycles from a granted address to valid mem_rdata (>=1)
//   SUM_W   15    sum width; DEPTH*(2^DATA_W-1) must fit, so no overflow is possible
// PORTS
//   clk        in   1       clock
//   rst        in   1       reset, synchronous, active-high
//   start      in   1       single-cycle request to begin a scan
//   grant      in   1       arbiter grant; mem_addr is consumed only when req&grant
//   mem_req    out  1       read port request
//   mem_addr   out  ADDR_W  read address
//   mem_rdata  in   DATA_W  read data, valid RD_LAT cycles after a granted cycle
//   busy       out  1       scan in progress (ISSUE or DRAIN)
//   done       out  1       one-cycle pulse: results valid
//   sum        out  SUM_W   sum of all entries
//   max_val    out  DATA_W  largest entry
//   max_addr   out  ADDR_W  lowest address holding max_val
//   carry_cnt  out  ADDR_W+1  number of entries with bit DATA_W-1 set
// BEHAVIOUR
//   Reset: state IDLE. All outputs are 0, including mem_req, mem_addr, busy,
//     done and all results. In-flight reads are discarded.
//     Reset mid-scan aborts the scan with no done pulse.
//   FSM states: IDLE, ISSUE, DRAIN, DONE.
//   IDLE: start=1 -> ISSUE. Issue address counter is set to 0.
//     sum, max_val, max_addr and carry_cnt are cleared on the same edge.
//   ISSUE: mem_req=1 and mem_addr = issue address.
//     On a cycle with grant=1: a read is issued, and the address advances.
//     On a cycle with grant=0: the address is held and nothing is issued.
//     Once address DEPTH-1 has been issued (granted) -> DRAIN. No wrap-around.
//   DRAIN: mem_req=0. Stays in DRAIN for exactly RD_LAT cycles,
//     until the last return is consumed -> DONE.
//   DONE: done=1 for one cycle -> IDLE.
//   Returns tracking:
//     A valid/address shift register of depth RD_LAT tags each granted issue.
//     mem_rdata is consumed only when the tagged valid bit emerges.
//   Accumulation, per consumed entry d at address a:
//     sum += zero-extended d.
//     carry_cnt += d[DATA_W-1].
//     If d > max_val (strictly greater): max_val = d and max_addr = a.
//       Ties therefore keep the lowest address.
//       An all-zero vector gives max_val=0 and max_addr=0.
//   Results are held stable after done until the next accepted start.
//   start while busy or in DONE is ignored and is not queued.
//   Latency with grant held at 1, start sampled at cycle 0:
//     ISSUE runs cycles 1..DEPTH, DRAIN runs RD_LAT cycles,
//     done is high in cycle DEPTH+RD_LAT+1.
//     Each grant=0 cycle in ISSUE adds one cycle.
//   busy = (state==ISSUE || state==DRAIN). busy is 0 in the cycle done is high.
// TESTING
//   1. All C=0, grant=1, pulse start -> done at cycle 1026.
//      sum=0, max_val=0, max_addr=0, carry_cnt=0.
//   2. All C=30 -> sum=30720, max_val=30, max_addr=0, carry_cnt=1024.
//   3. C[513]=17, all other entries 1 -> sum=1040, max_val=17, max_addr=513,
//      carry_cnt=1.
//   4. Data as in 3, grant toggling 1/0 every cycle -> results identical to 3.
//      done is delayed by the number of denied cycles.
//      mem_addr never skips and never repeats a consumed address.
//   5. start re-pulsed at cycle 200 of a scan -> ignored, exactly one done.
//      Then start after done -> results recomputed and cleared at start.
//   6. rst asserted at address 600 -> next cycle all outputs 0, no done.
//      A fresh start then gives the correct results of scenario 3.

Source files
------------

// File: rtl/vector_c_reduce_if.sv
`default_nettype none
// ============================================================================
// Module   : vector_c_reduce_if
// Brief    : Start/result handshake and shared read-port bus of the vector C
//            reduction block. Signal suffixes are from the reducer's viewpoint.
// Revision : 1.0 - initial release
// ============================================================================
interface vector_c_reduce_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 5,
    parameter int SUM_W  = 15
);
    logic              start_i;
    logic              grant_i;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              mem_req_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              busy_o;
    logic              done_o;
    logic [SUM_W-1:0]  sum_o;
    logic [DATA_W-1:0] max_val_o;
    logic [ADDR_W-1:0] max_addr_o;
    logic [ADDR_W:0]   carry_cnt_o;

    // Reducer side: masters the read port, reports results.
    modport master (
        input  start_i, grant_i, mem_rdata_i,
        output mem_req_o, mem_addr_o, busy_o, done_o,
               sum_o, max_val_o, max_addr_o, carry_cnt_o
    );

    // Requester / memory side.
    modport slave (
        output start_i, grant_i, mem_rdata_i,
        input  mem_req_o, mem_addr_o, busy_o, done_o,
               sum_o, max_val_o, max_addr_o, carry_cnt_o
    );
endinterface
`default_nettype wire

// File: rtl/vector_c_reduce.sv
`default_nettype none
// ============================================================================
// Module   : vector_c_reduce
// Brief    : Scans every entry of vector C through an arbitrated read port and
//            reports sum, maximum (lowest address on ties) and carry count.
// Revision : 1.0 - initial release
// ============================================================================
module vector_c_reduce #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024,
    parameter int DATA_W = 5,
    parameter int RD_LAT = 1,
    parameter int SUM_W  = 15
) (
    input wire              clk,
    input wire              rst,
    vector_c_reduce_if.master bus
);

    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [ADDR_W-1:0] c_last_addr  = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  c_drain_last = CNT_W'(RD_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic              mem_req_q;
    logic              busy_q;
    logic              done_q;
    logic [CNT_W-1:0]  drain_q;

    // Return tracking: one valid bit and address tag per read in flight.
    logic [RD_LAT-1:0] vld_q;
    logic [ADDR_W-1:0] tag_q [RD_LAT];

    logic [SUM_W-1:0]  sum_q,       sum_d;
    logic [DATA_W-1:0] max_val_q,   max_val_d;
    logic [ADDR_W-1:0] max_addr_q,  max_addr_d;
    logic [ADDR_W:0]   carry_cnt_q, carry_cnt_d;

    // mem_req_q is only ever high in ISSUE, so this is "a read was accepted".
    wire w_issue   = mem_req_q & bus.grant_i;
    wire w_clear   = (state_q == S_IDLE) & bus.start_i;
    wire w_consume = vld_q[RD_LAT-1];
    wire [ADDR_W-1:0] w_cons_addr = tag_q[RD_LAT-1];

    // Scan sequencer with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            mem_req_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            drain_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start_i) begin
                        state_q   <= S_ISSUE;
                        addr_q    <= '0;
                        mem_req_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (bus.grant_i) begin
                        if (addr_q == c_last_addr) begin
                            // Address is held at the last entry: no wrap-around.
                            state_q   <= S_DRAIN;
                            mem_req_q <= 1'b0;
                            drain_q   <= '0;
                        end else begin
                            addr_q <= addr_q + ADDR_W'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_q == c_drain_last) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        drain_q <= drain_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Shift granted addresses along so each return knows where it came from.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            for (int k = 0; k < RD_LAT; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            for (int k = RD_LAT - 1; k > 0; k--) begin
                vld_q[k] <= vld_q[k-1];
                tag_q[k] <= tag_q[k-1];
            end
            vld_q[0] <= w_issue;
            tag_q[0] <= addr_q;
        end
    end

    // Next-state of the results: cleared on an accepted start, updated per return.
    always_comb begin
        sum_d       = sum_q;
        max_val_d   = max_val_q;
        max_addr_d  = max_addr_q;
        carry_cnt_d = carry_cnt_q;
        if (w_clear) begin
            sum_d       = '0;
            max_val_d   = '0;
            max_addr_d  = '0;
            carry_cnt_d = '0;
        end else if (w_consume) begin
            sum_d       = sum_q + SUM_W'(bus.mem_rdata_i);
            carry_cnt_d = carry_cnt_q + (ADDR_W + 1)'(bus.mem_rdata_i[DATA_W-1]);
            // Strictly greater, so an equal later value keeps the lower address.
            if (bus.mem_rdata_i > max_val_q) begin
                max_val_d  = bus.mem_rdata_i;
                max_addr_d = w_cons_addr;
            end
        end
    end

    // Result registers, held between scans.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q       <= '0;
            max_val_q   <= '0;
            max_addr_q  <= '0;
            carry_cnt_q <= '0;
        end else begin
            sum_q       <= sum_d;
            max_val_q   <= max_val_d;
            max_addr_q  <= max_addr_d;
            carry_cnt_q <= carry_cnt_d;
        end
    end

    assign bus.mem_req_o   = mem_req_q;
    assign bus.mem_addr_o  = addr_q;
    assign bus.busy_o      = busy_q;
    assign bus.done_o      = done_q;
    assign bus.sum_o       = sum_q;
    assign bus.max_val_o   = max_val_q;
    assign bus.max_addr_o  = max_addr_q;
    assign bus.carry_cnt_o = carry_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_vector_c_reduce.sv
`default_nettype none
// ============================================================================
// Module   : tb_vector_c_reduce
// Brief    : Self-checking bench for vector_c_reduce with a memory/arbiter model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vector_c_reduce;

    localparam int DEPTH = 1024;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    logic [4:0] mem [DEPTH];
    logic [4:0] rdata_q;

    vector_c_reduce_if bus ();

    vector_c_reduce dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory with a one-cycle read latency; garbage when no read was granted.
    always @(posedge clk) begin
        if (bus.mem_req_o && bus.grant_i)
            rdata_q <= mem[bus.mem_addr_o];
        else
            rdata_q <= 5'($urandom);
    end
    assign bus.mem_rdata_i = rdata_q;

    typedef struct {
        string nm;
        int    pat;
        int    gmode;
        int    restart;
        bit    sid;
        int    e_sum;
        int    e_max;
        int    e_maddr;
        int    e_carry;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic fill(input int pat);
        for (int a = 0; a < DEPTH; a++) begin
            case (pat)
                0:       mem[a] = 5'd0;
                1:       mem[a] = 5'd30;
                2:       mem[a] = (a == 513) ? 5'd17 : 5'd1;
                3:       mem[a] = (a == DEPTH - 1) ? 5'd31 : 5'd0;
                default: mem[a] = 5'($urandom_range(0, 31));
            endcase
        end
    endtask

    // Reference: straight walk over the array.
    task automatic ref_model(output int s, output int mx, output int ma, output int cc);
        s = 0; mx = 0; ma = 0; cc = 0;
        for (int a = 0; a < DEPTH; a++) begin
            s += int'(mem[a]);
            if (mem[a] >= 5'd16) cc++;
            if (int'(mem[a]) > mx) begin
                mx = int'(mem[a]);
                ma = a;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete scan; cycle 0 is the cycle in which start is sampled.
    task automatic run_scan(input string nm, input int gmode, input int restart_cyc,
                            input bit start_in_done, input int e_sum, input int e_max,
                            input int e_maddr, input int e_carry);
        int cyc, denied, exp_a, done_cyc;
        bit g, addr_bad, req_bad, busy_bad, extra;
        cyc = 0; denied = 0; exp_a = 0; done_cyc = -1;
        addr_bad = 0; req_bad = 0; busy_bad = 0; extra = 0;
        bus.start_i = 1'b1;
        bus.grant_i = 1'b0;
        step();
        bus.start_i = 1'b0;
        cyc = 1;
        while (cyc <= 5000) begin
            if (cyc == 1)
                chk({nm, ".clear_at_start"},
                    {bus.sum_o, bus.max_val_o, bus.carry_cnt_o, 1'b0}, 32'd0 | {31'd0, 1'b0} | (bus.max_addr_o != 0));
            if (bus.done_o) begin
                done_cyc = cyc;
                break;
            end
            if (!bus.busy_o) busy_bad = 1;
            if (bus.mem_req_o !== (exp_a < DEPTH)) req_bad = 1;
            case (gmode)
                0:       g = 1'b1;
                1:       g = (cyc % 2 == 1);
                default: g = ($urandom_range(0, 3) != 0);
            endcase
            bus.grant_i = g;
            bus.start_i = (cyc == restart_cyc);
            if (bus.mem_req_o) begin
                if (g) begin
                    if (bus.mem_addr_o !== 10'(exp_a)) addr_bad = 1;
                    exp_a++;
                end else begin
                    denied++;
                end
            end
            step();
            cyc++;
        end
        chk({nm, ".done_cycle"}, done_cyc, DEPTH + denied + 2);
        chk({nm, ".busy_during_scan"}, busy_bad, 0);
        chk({nm, ".busy_in_done"}, bus.busy_o, 0);
        chk({nm, ".addr_seq"}, addr_bad, 0);
        chk({nm, ".req_window"}, req_bad, 0);
        chk({nm, ".issued_count"}, exp_a, DEPTH);
        chk({nm, ".sum"}, bus.sum_o, e_sum);
        chk({nm, ".max_val"}, bus.max_val_o, e_max);
        chk({nm, ".max_addr"}, bus.max_addr_o, e_maddr);
        chk({nm, ".carry_cnt"}, bus.carry_cnt_o, e_carry);
        // Start in the done cycle must be dropped; no second done, no new scan.
        bus.grant_i = 1'b0;
        bus.start_i = start_in_done;
        for (int i = 0; i < 10; i++) begin
            step();
            bus.start_i = 1'b0;
            if (bus.done_o || bus.busy_o) extra = 1;
        end
        chk({nm, ".single_done_idle"}, extra, 0);
        chk({nm, ".results_held"},
            {bus.sum_o, bus.max_val_o, bus.max_addr_o, 2'b0},
            {15'(e_sum), 5'(e_max), 10'(e_maddr), 2'b0});
    endtask

    initial begin
        int s, mx, ma, cc, n;
        bit late;
        total = 0;
        bad   = 0;
        tbl[0] = '{"zeros",     0, 0, -1,  0,     0,  0,    0,    0};
        tbl[1] = '{"all30",     1, 0, -1,  0, 30720, 30,    0, 1024};
        tbl[2] = '{"peak513",   2, 0, -1,  0,  1040, 17,  513,    1};
        tbl[3] = '{"toggle",    2, 1, -1,  0,  1040, 17,  513,    1};
        tbl[4] = '{"restart",   2, 0, 200, 1,  1040, 17,  513,    1};
        tbl[5] = '{"last_addr", 3, 0, -1,  0,    31, 31, 1023,    1};

        rst = 1'b1;
        bus.start_i = 1'b0;
        bus.grant_i = 1'b0;
        fill(0);
        repeat (3) step();
        chk("reset.req_addr", {bus.mem_req_o, bus.mem_addr_o}, 0);
        chk("reset.busy_done", {bus.busy_o, bus.done_o}, 0);
        chk("reset.results", {bus.sum_o, bus.max_val_o, bus.max_addr_o} | 32'(bus.carry_cnt_o), 0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 6; i++) begin
            fill(tbl[i].pat);
            run_scan(tbl[i].nm, tbl[i].gmode, tbl[i].restart, tbl[i].sid,
                     tbl[i].e_sum, tbl[i].e_max, tbl[i].e_maddr, tbl[i].e_carry);
        end

        for (int r = 0; r < 3; r++) begin
            fill(4);
            ref_model(s, mx, ma, cc);
            run_scan($sformatf("rnd%0d", r), 2, -1, 0, s, mx, ma, cc);
        end

        // Reset in the middle of a scan.
        fill(2);
        bus.start_i = 1'b1;
        bus.grant_i = 1'b1;
        step();
        bus.start_i = 1'b0;
        n = 0;
        while (bus.mem_addr_o != 10'd600 && n < 2000) begin
            step();
            n++;
        end
        chk("midrst.reached_600", (n < 2000), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst.req_addr", {bus.mem_req_o, bus.mem_addr_o}, 0);
        chk("midrst.busy_done", {bus.busy_o, bus.done_o}, 0);
        chk("midrst.results", {bus.sum_o, bus.max_val_o, bus.max_addr_o} | 32'(bus.carry_cnt_o), 0);
        late = 0;
        for (int i = 0; i < 1100; i++) begin
            step();
            if (bus.done_o || bus.busy_o) late = 1;
        end
        chk("midrst.no_done", late, 0);
        run_scan("after_rst", 0, -1, 0, 1040, 17, 513, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
